// File: rtl/fetch_decode.sv
// Instruction front end: fetches 32-bit words, issues executable opcodes to execute with a
// one-cycle strobe, and resolves NOP/JMP/HALT and illegal words locally.
module fetch_decode #(
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  output logic              exe_en,
  output logic [1:0]        exe_pfix,
  output logic [5:0]        exe_opcode,
  output logic [3:0]        exe_rs,
  output logic [3:0]        exe_rd,
  output logic [15:0]       exe_imm,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalted} state_e;
  typedef enum logic [2:0] {OpExec, OpNop, OpJmp, OpHalt, OpIllegal} op_kind_e;

  state_e   state_q;
  op_kind_e issue_kind;

  // pfix only matters for executable opcodes; 01/10 there is undecodable.
  function automatic op_kind_e decode_kind(input logic [1:0] pfix, input logic [5:0] opcode);
    op_kind_e kind;
    case (opcode)
      6'h00:   kind = OpNop;
      6'h01:   kind = OpJmp;
      6'h3f:   kind = OpHalt;
      6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0d:
        kind = (pfix == 2'b01 || pfix == 2'b10) ? OpIllegal : OpExec;
      default: kind = OpIllegal;
    endcase
    return kind;
  endfunction

  assign issue_kind = decode_kind(exe_pfix, exe_opcode);
  assign imem_addr  = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc         <= RESET_PC;
      imem_req   <= 1'b0;
      exe_en     <= 1'b0;
      exe_pfix   <= '0;
      exe_opcode <= '0;
      exe_rs     <= '0;
      exe_rd     <= '0;
      exe_imm    <= '0;
      halted     <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      exe_en <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (run) begin
            state_q  <= StFetch;
            imem_req <= 1'b1;
          end
        end
        StFetch: begin
          if (imem_valid) begin
            {exe_pfix, exe_opcode, exe_rs, exe_rd, exe_imm} <= imem_rdata;
            // Strobe is registered so it lines up with the fields in the ISSUE cycle.
            exe_en   <= (decode_kind(imem_rdata[31:30], imem_rdata[29:24]) == OpExec);
            imem_req <= 1'b0;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (issue_kind == OpHalt || issue_kind == OpIllegal) begin
            state_q <= StHalted;
            halted  <= 1'b1;
            if (issue_kind == OpIllegal) illegal <= 1'b1;
          end else begin
            state_q  <= run ? StFetch : StIdle;
            imem_req <= run;
            pc       <= (issue_kind == OpJmp) ? exe_imm[ADDR_W-1:0] : pc + ADDR_W'(1);
          end
        end
        StHalted: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: a program-level reference model queues expected issues
// and fetch addresses; memory-side and execute-side monitors pop and compare independently.
module tb_fetch_decode;
  localparam int unsigned   AW  = 8;
  localparam logic [AW-1:0] RPC = 8'h05;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic imem_req, imem_valid = 1'b0;
  logic [AW-1:0] imem_addr, pc;
  logic [31:0] imem_rdata = '0;
  logic exe_en, halted, illegal;
  logic [1:0] exe_pfix;
  logic [5:0] exe_opcode;
  logic [3:0] exe_rs, exe_rd;
  logic [15:0] exe_imm;

  logic s_run = 1'b0;
  logic s_valid = 1'b1;
  logic [31:0] s_rdata = '0;
  logic s_req, s_en, s_halted, s_ill;
  logic [3:0] s_addr, s_pc, s_rs, s_rd;
  logic [1:0] s_pfix;
  logic [5:0] s_op;
  logic [15:0] s_imm;

  fetch_decode #(.ADDR_W(AW), .RESET_PC(RPC)) u_dut (
    .clk(clk), .rst(rst), .run(run), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid), .exe_en(exe_en), .exe_pfix(exe_pfix),
    .exe_opcode(exe_opcode), .exe_rs(exe_rs), .exe_rd(exe_rd), .exe_imm(exe_imm), .pc(pc),
    .halted(halted), .illegal(illegal)
  );

  fetch_decode #(.ADDR_W(4), .RESET_PC(4'hF)) u_small (
    .clk(clk), .rst(rst), .run(s_run), .imem_req(s_req), .imem_addr(s_addr),
    .imem_rdata(s_rdata), .imem_valid(s_valid), .exe_en(s_en), .exe_pfix(s_pfix),
    .exe_opcode(s_op), .exe_rs(s_rs), .exe_rd(s_rd), .exe_imm(s_imm), .pc(s_pc),
    .halted(s_halted), .illegal(s_ill)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [31:0]   w;
  } iss_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [31:0] mem [256];
  logic [5:0] exec_ops [9] = '{6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08, 6'h09, 6'h0a, 6'h0d};
  iss_t exp_q[$];
  logic [AW-1:0] fetch_q[$];
  int en_cyc[$];
  int fixed_wait = 0;
  int max_wait = 0;
  int wait_tgt = 0;
  int wait_cnt = 0;
  bit new_req = 1'b1;
  logic [AW-1:0] start_addr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory responder, also checks each completed fetch address against the model.
  always @(negedge clk) begin
    if (!imem_req) begin
      imem_valid = 1'b0;
      new_req = 1'b1;
    end else begin
      if (new_req) begin
        new_req = 1'b0;
        wait_cnt = 0;
        start_addr = imem_addr;
        wait_tgt = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(max_wait, 0));
      end
      if (wait_cnt >= wait_tgt) begin
        imem_valid = 1'b1;
        imem_rdata = mem[imem_addr];
        if (!rst) begin
          if (wait_tgt > 0) check("fetch_addr_held", 32'(imem_addr), 32'(start_addr));
          if (fetch_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL fetch_unexpected: got addr %h want no fetch", imem_addr);
          end else begin
            check("fetch_addr", 32'(imem_addr), 32'(fetch_q.pop_front()));
          end
        end
      end else begin
        imem_valid = 1'b0;
        wait_cnt++;
      end
    end
  end

  // Execute-side monitor.
  always @(negedge clk) begin
    iss_t e;
    if (!rst && exe_en) begin
      en_cyc.push_back(cyc);
      check("exe_no_req", 32'(imem_req), 32'h0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL exe_unexpected: got exe_en=1 pc=%h want no issue", pc);
      end else begin
        e = exp_q.pop_front();
        check("exe_fields", {exe_pfix, exe_opcode, exe_rs, exe_rd, exe_imm}, e.w);
        check("exe_pc", 32'(pc), 32'(e.pc));
      end
    end
  end

  // 0 exec, 1 nop, 2 jmp, 3 halt, 4 illegal
  function automatic int classify(input logic [31:0] w);
    logic [5:0] op;
    logic [1:0] pf;
    op = w[29:24];
    pf = w[31:30];
    if (op == 6'h00) return 1;
    if (op == 6'h01) return 2;
    if (op == 6'h3f) return 3;
    foreach (exec_ops[i]) if (op == exec_ops[i]) return (pf == 2'b00 || pf == 2'b11) ? 0 : 4;
    return 4;
  endfunction

  // Walks the program in mem from RPC, queueing fetches and issues.
  task automatic model(output logic m_ill, output logic [AW-1:0] m_pc);
    logic [AW-1:0] p;
    logic [31:0] w;
    int kind;
    iss_t e;
    p = RPC;
    m_ill = 1'b0;
    for (int s = 0; s < 300; s++) begin
      w = mem[p];
      fetch_q.push_back(p);
      kind = classify(w);
      if (kind == 0) begin
        e.pc = p;
        e.w = w;
        exp_q.push_back(e);
        p = p + 1'b1;
      end else if (kind == 1) begin
        p = p + 1'b1;
      end else if (kind == 2) begin
        p = w[AW-1:0];
      end else begin
        m_ill = (kind == 4);
        break;
      end
    end
    m_pc = p;
  endtask

  task automatic clear_mem();
    foreach (mem[i]) mem[i] = 32'h3F00_0000;
  endtask

  task automatic gen_prog(input int n);
    logic [31:0] rnd, w;
    logic [AW-1:0] a, tgt;
    int r;
    clear_mem();
    for (int i = 0; i < n; i++) begin
      a = RPC + AW'(i);
      rnd = $urandom;
      r = $urandom_range(99, 0);
      if (r < 60) w = {(rnd[31] ? 2'b11 : 2'b00), exec_ops[$urandom_range(8, 0)], rnd[23:0]};
      else if (r < 75) w = {rnd[31:30], 6'h00, rnd[23:0]};
      else if (r < 88) begin
        tgt = a + AW'(1) + AW'($urandom_range(4, 0));
        w = {rnd[31:30], 6'h01, rnd[23:16], rnd[15:8], tgt};
      end
      else if (r < 92) w = {(rnd[31] ? 2'b01 : 2'b10), exec_ops[$urandom_range(8, 0)], rnd[23:0]};
      else if (r < 97) w = {rnd[31:30], 6'($urandom_range(62, 14)), rnd[23:0]};
      else w = {rnd[31:30], 6'h3f, rnd[23:0]};
      mem[a] = w;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst = 1'b1;
    run = 1'b0;
    s_run = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rst_req"}, 32'(imem_req), 32'h0);
    check({tag, "_rst_addr"}, 32'(imem_addr), 32'(RPC));
    check({tag, "_rst_pc"}, 32'(pc), 32'(RPC));
    check({tag, "_rst_en"}, 32'(exe_en), 32'h0);
    check({tag, "_rst_fields"}, {exe_pfix, exe_opcode, exe_rs, exe_rd, exe_imm}, 32'h0);
    check({tag, "_rst_halted"}, 32'(halted), 32'h0);
    check({tag, "_rst_illegal"}, 32'(illegal), 32'h0);
  endtask

  task automatic start_prog(output logic m_ill, output logic [AW-1:0] m_pc, output int t0);
    do_reset();
    exp_q.delete();
    fetch_q.delete();
    en_cyc.delete();
    model(m_ill, m_pc);
    run = 1'b1;
    t0 = cyc;
  endtask

  task automatic finish_prog(input string tag, input logic m_ill, input logic [AW-1:0] m_pc,
                             output int hcyc);
    for (int i = 0; i < 3000 && !halted; i++) begin
      @(posedge clk); #2;
    end
    hcyc = cyc;
    check({tag, "_halted"}, 32'(halted), 32'h1);
    check({tag, "_illegal"}, 32'(illegal), 32'(m_ill));
    check({tag, "_pc"}, 32'(pc), 32'(m_pc));
    check({tag, "_req_off"}, 32'(imem_req), 32'h0);
    check({tag, "_issues_left"}, exp_q.size(), 32'h0);
    check({tag, "_fetches_left"}, fetch_q.size(), 32'h0);
  endtask

  initial begin
    logic m_ill;
    logic [AW-1:0] m_pc;
    int t0, hcyc;
    logic [3:0] seen[$];
    logic prev;

    clear_mem();
    do_reset();
    check_reset_vals("init");

    // Zero-wait directed program: ADD, MV, HALT.
    fixed_wait = 0;
    mem[RPC] = 32'h0412_0005;
    mem[RPC+1] = 32'hC303_00AA;
    mem[RPC+2] = 32'h3F00_0000;
    start_prog(m_ill, m_pc, t0);
    finish_prog("zw", m_ill, m_pc, hcyc);
    check("zw_pc_abs", 32'(pc), 32'(RPC + 8'd2));
    check("zw_en_count", en_cyc.size(), 32'd2);
    if (en_cyc.size() == 2) begin
      check("zw_en_cyc0", en_cyc[0] - t0, 32'd2);
      check("zw_en_cyc1", en_cyc[1] - t0, 32'd4);
    end
    check("zw_halt_cyc", hcyc - t0, 32'd7);

    // Three wait cycles per fetch.
    fixed_wait = 3;
    clear_mem();
    mem[RPC] = 32'h0412_0005;
    mem[RPC+1] = 32'h0534_0007;
    mem[RPC+2] = 32'hCD56_0000;
    start_prog(m_ill, m_pc, t0);
    finish_prog("ws", m_ill, m_pc, hcyc);
    check("ws_en_count", en_cyc.size(), 32'd3);
    if (en_cyc.size() == 3) begin
      check("ws_en_gap0", en_cyc[1] - en_cyc[0], 32'd5);
      check("ws_en_gap1", en_cyc[2] - en_cyc[1], 32'd5);
    end

    // JMP then NOP, neither issued.
    fixed_wait = 0;
    clear_mem();
    mem[RPC] = 32'h0100_0010;
    mem[8'h10] = 32'h0000_0000;
    start_prog(m_ill, m_pc, t0);
    finish_prog("jmp", m_ill, m_pc, hcyc);
    check("jmp_pc_abs", 32'(pc), 32'h11);
    check("jmp_no_en", en_cyc.size(), 32'd0);

    // Illegal pfix on ADD, then run toggling while halted.
    clear_mem();
    mem[RPC] = 32'h0000_0000;
    mem[RPC+1] = 32'h4412_0005;
    start_prog(m_ill, m_pc, t0);
    finish_prog("ilpf", m_ill, m_pc, hcyc);
    check("ilpf_flag", 32'(illegal), 32'h1);
    check("ilpf_pc_abs", 32'(pc), 32'(RPC + 8'd1));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      run = ~run;
    end
    check("ilpf_stay_halted", 32'(halted), 32'h1);
    check("ilpf_stay_pc", 32'(pc), 32'(RPC + 8'd1));
    check("ilpf_stay_req", 32'(imem_req), 32'h0);
    check("ilpf_stay_ill", 32'(illegal), 32'h1);
    do_reset();
    check_reset_vals("after_ill");

    // Unknown opcode 0x20.
    clear_mem();
    mem[RPC] = 32'h2000_0000;
    start_prog(m_ill, m_pc, t0);
    finish_prog("ilop", m_ill, m_pc, hcyc);
    check("ilop_flag", 32'(illegal), 32'h1);
    check("ilop_no_en", en_cyc.size(), 32'd0);

    // Reset mid-FETCH with data arriving in the same cycle.
    clear_mem();
    mem[RPC] = 32'h0412_0005;
    mem[RPC+1] = 32'h0534_0007;
    start_prog(m_ill, m_pc, t0);
    for (int i = 0; i < 50 && en_cyc.size() == 0; i++) begin
      @(posedge clk); #2;
    end
    for (int i = 0; i < 50 && !imem_req; i++) begin
      @(posedge clk); #2;
    end
    check("mf_in_fetch", 32'(imem_req), 32'h1);
    rst = 1'b1;
    run = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;
    exp_q.delete();
    fetch_q.delete();
    en_cyc.delete();
    check("mf_pc", 32'(pc), 32'(RPC));
    check("mf_req", 32'(imem_req), 32'h0);
    check("mf_en", 32'(exe_en), 32'h0);
    check("mf_fields", {exe_pfix, exe_opcode, exe_rs, exe_rd, exe_imm}, 32'h0);
    repeat (3) begin
      @(posedge clk); #2;
    end
    check("mf_idle_req", 32'(imem_req), 32'h0);
    check("mf_no_en", en_cyc.size(), 32'd0);
    model(m_ill, m_pc);
    run = 1'b1;
    finish_prog("mf_restart", m_ill, m_pc, hcyc);

    // Randomized programs with random memory latency.
    fixed_wait = -1;
    max_wait = 2;
    for (int k = 0; k < 10; k++) begin
      gen_prog($urandom_range(30, 10));
      start_prog(m_ill, m_pc, t0);
      finish_prog("rnd", m_ill, m_pc, hcyc);
    end

    // ADDR_W=4 instance: NOPs from pc=15 wrap to 0.
    fixed_wait = 0;
    do_reset();
    s_run = 1'b1;
    prev = 1'b0;
    for (int i = 0; i < 20 && seen.size() < 3; i++) begin
      @(posedge clk); #2;
      if (s_req && !prev) seen.push_back(s_addr);
      prev = s_req;
    end
    s_run = 1'b0;
    check("wrap_fetches", seen.size(), 32'd3);
    if (seen.size() == 3) begin
      check("wrap_addr0", 32'(seen[0]), 32'hF);
      check("wrap_addr1", 32'(seen[1]), 32'h0);
      check("wrap_addr2", 32'(seen[2]), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction front end for the simple CPU. Fetches 32-bit instruction words from instruction memory and splits each word into the pfix/opcode/rs/rd/imm fields. Issues each executable instruction to the `execute` stage with a one-cycle `exe_en` pulse. Control-flow opcodes (NOP, JMP, HALT) are handled locally and never reach `execute`.

## Interface

Parameters:
- `ADDR_W`, 16, instruction address width (word addressed), 1..16
- `RESET_PC`, 0, PC value loaded on reset

Ports:
- `clk`  input  1  rising-edge clock
- `rst`  input  1  synchronous, active-high reset
- `run`  input  1  start/continue request
- `imem_req`  output  1  fetch request, held until `imem_valid`
- `imem_addr`  output  ADDR_W  fetch address (equals `pc`)
- `imem_rdata`  input  32  instruction word, valid when `imem_valid`
- `imem_valid`  input  1  read data valid (same cycle as `imem_req` or later)
- `exe_en`  output  1  one-cycle issue strobe to `execute`
- `exe_pfix`  output  2  word[31:30]
- `exe_opcode`  output  6  word[29:24]
- `exe_rs`  output  4  word[23:20]
- `exe_rd`  output  4  word[19:16]
- `exe_imm`  output  16  word[15:0]
- `pc`  output  ADDR_W  current program counter
- `halted`  output  1  high in HALTED state
- `illegal`  output  1  sticky, set when an undecodable word caused the halt

## Operation

- States: IDLE, FETCH, ISSUE, HALTED. Reset enters IDLE.
- IDLE: `imem_req`=0. If `run`=1, go to FETCH.
- FETCH:
  - `imem_req`=1, `imem_addr`=`pc`.
  - On a cycle with `imem_valid`=1, latch `imem_rdata` into the instruction register and go to ISSUE.
  - Otherwise stay in FETCH with the address held.
- ISSUE: decode the latched word.
  - Executable opcodes: MV 000011, ADD 000100, SUB 000101, SHR 000110, SHL 000111, AND 001000, OR 001001, XOR 001010, OUTW 001101, each with pfix 00 or 11.
    - `exe_en`=1 for this cycle only.
    - `pc`<=`pc`+1.
  - NOP 000000: no `exe_en`; `pc`<=`pc`+1.
  - JMP 000001: no `exe_en`; `pc`<=`imm[ADDR_W-1:0]`.
  - HALT 111111: no `exe_en`; `pc` unchanged; go to HALTED.
  - Illegal word: no `exe_en`; `illegal`<=1; `pc` unchanged; go to HALTED. A word is illegal if:
    - any other opcode, or
    - pfix 01 or 10 on an executable opcode.
    - pfix is don't-care for NOP, JMP and HALT.
  - Next state when not halting: FETCH if `run`=1, else IDLE.
- HALTED: `imem_req`=0 and `halted`=1. Only `rst` leaves this state; `run` is ignored.
- `exe_pfix`/`exe_opcode`/`exe_rs`/`exe_rd`/`exe_imm` are registered.
  - They update on the clock edge entering ISSUE, for every fetched word.
  - They are stable from that edge until the next fetch completes.
- PC arithmetic is modulo 2^ADDR_W: `pc`=2^ADDR_W-1 followed by +1 gives 0.
- When ADDR_W<16, JMP uses the low ADDR_W bits of imm only.
- `imem_valid` is ignored outside FETCH.
- Reset in any state, including mid-FETCH:
  - IDLE; `pc`=RESET_PC.
  - All other outputs 0, and `illegal` cleared.
  - Any outstanding memory response is discarded.
  - Instruction memory shares `rst` and drops its pending read.

## Timing

- Reset values: `imem_req`=0, `imem_addr`=`pc`=RESET_PC, `exe_en`=0, all `exe_*` fields=0, `halted`=0, `illegal`=0.
- Zero-wait memory (`imem_valid` in the same cycle as `imem_req`): 2 cycles per instruction, FETCH then ISSUE. Back-to-back execution gives `exe_en` high every second cycle.
- Each memory wait cycle adds one cycle in FETCH.
- IDLE with `run`=1 at edge N: `imem_req`=1 in cycle N+1.
- `exe_en` is asserted in the cycle after the `imem_valid` edge. `execute` samples the fields during that cycle.
- `pc` increments (or jumps) on the edge leaving ISSUE. The next `imem_addr` therefore reflects the new PC in the first FETCH cycle.
- `halted` rises on the edge leaving ISSUE for HALT or illegal.
- `run` is sampled only in IDLE and at the end of ISSUE. Deasserting it mid-FETCH completes that instruction first.

## Test plan

- Reset, `run`=1, zero-wait memory with words 0x04_1_2_0005 (ADD rs=1 rd=2), 0xC3_0_3_00AA (MV rd=3 imm=0xAA), 0x3F000000 (HALT):
  - `exe_en` pulses in cycles 2 and 4.
  - Fields are 00/000100/1/2/0005, then 11/000011/0/3/00AA.
  - `halted`=1 after cycle 6 with `pc`=2.
- Memory inserting 3 wait cycles per fetch:
  - `imem_req` and `imem_addr` are held constant for 4 cycles.
  - Exactly one `exe_en` per instruction.
  - No `exe_en` during waits.
- JMP 0x01000010 at pc=0 then NOP at 0x10: no `exe_en` for either; fetch addresses are 0, 0x10, 0x11.
- Illegal cases, each with no `exe_en`, `illegal`=1, `halted`=1, `pc` held at the faulting address:
  - pfix 01 on ADD;
  - opcode 0x20.
  - `run` toggling afterwards has no effect until `rst`.
- ADDR_W=4, run through NOPs from pc=15: next `imem_addr`=0.
- `rst` asserted mid-FETCH with `imem_valid` arriving in the same cycle:
  - word discarded, IDLE, `pc`=RESET_PC, no `exe_en`.
  - `run`=1 restarts the fetch at RESET_PC.
